panel_frame_loader: RTL and testbench
=====================================

# panel_frame_loader

Double-buffered frame store sitting directly upstream of the LED panel scan driver. A host shifts a full RGB frame in over a three-wire serial link (clock, data, select). The panel driver requests pixels by row/column and receives 3-bit colour one cycle later. Completed frames are swapped into the display buffer only at a driver frame boundary, so the panel never shows a partially loaded image.

## Interface
- COLS, 32, pixels per row; power of two, 4..64
- ROWS, 4, scan rows (matches 2-bit a/b row select); power of two, 2..8
- CW, $clog2(COLS), column index width (derived)
- RW, $clog2(ROWS), row index width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load_sclk  in  1  host serial clock; asynchronous to clk
- load_data  in  1  host serial data, sampled on load_sclk rising edge
- load_cs_n  in  1  host frame select, active-low
- load_ready  out  1  high when a new frame may be loaded
- frame_sync  in  1  one-cycle pulse from driver at start of each panel frame
- pix_req  in  1  driver pixel read request
- pix_row  in  RW  requested row, sampled with pix_req
- pix_col  in  CW  requested column, sampled with pix_req
- pix_valid  out  1  pix_rgb valid this cycle
- pix_rgb  out  3  [2]=red, [1]=green, [0]=blue
- frame_done  out  1  one-cycle pulse when a new frame becomes visible

## Operation
- Storage: two banks, each ROWS*COLS*3 bits, held in flops. disp_sel selects the display bank; the other bank is the write bank.
- Input sync: load_sclk, load_data and load_cs_n each pass through a 2-flop synchronizer. A third flop on load_sclk gives rising-edge detection. Data is captured from the synchronized load_data on a detected edge.
- Loader FSM states: IDLE, SHIFT, FULL.
  - IDLE -> SHIFT: synchronized load_cs_n falls while load_ready=1. Bit counter and pixel pointer are cleared.
  - SHIFT: each sclk edge shifts one bit. Per pixel, the bit order is R, G, B. Pixels are row-major: row 0 col 0 first, then col 1 up to col COLS-1, then row 1, and so on.
  - After the 3rd bit of a pixel, that pixel is written to the write bank. The pointer then increments.
  - SHIFT -> FULL: the write of pixel ROWS*COLS-1 completes. swap_pending is set and load_ready drops.
  - SHIFT -> IDLE: load_cs_n rises before the frame is complete. The partial frame is abandoned: no swap, write-bank contents are undefined for display purposes.
  - FULL: further sclk edges are ignored. The FSM moves FULL -> IDLE when cs_n is high and the swap has occurred.
- Swap: on a frame_sync cycle with swap_pending=1 already registered:
  - disp_sel toggles;
  - swap_pending clears;
  - frame_done pulses in the same cycle;
  - load_ready rises the next cycle.
- Read: pix_req registers {pix_row, pix_col}. The next cycle, pix_rgb is driven from the display bank and pix_valid=1. pix_rgb holds its last value when pix_valid=0.
- Back-to-back pix_req on consecutive cycles is supported at full throughput.

## Timing
- Reset values:
  - pix_rgb=0, pix_valid=0, frame_done=0, load_ready=1
  - disp_sel=0, swap_pending=0, FSM=IDLE
  - both banks all zero (panel shows black)
- Read latency is exactly 1 clk from pix_req to pix_valid.
- The address used is the one registered at the pix_req cycle. A read issued in the swap cycle returns pre-swap bank data; reads from the following cycle return the new bank.
- Serial input limits: load_sclk high and low phases are each >= 3 clk. Data must be stable 3 clk before and after the rising edge. From a load_sclk pin edge to capture takes 3 clk.
- frame_sync in the same cycle that swap_pending is set: no swap. The swap happens at the next frame_sync.
- cs_n fall while load_ready=0 is ignored. The host must wait for load_ready.
- Reset asserted mid-load or mid-read clears everything asynchronously. Outputs take their reset values immediately.

## Test plan
- Reset: assert reset low mid-operation -> pix_valid=0, pix_rgb=0, load_ready=1. Reads of any address after release return 3'b000.
- Full load: COLS=32, ROWS=4; shift 384 bits with pixel (r,c)=((r*32+c)%8), then pulse frame_sync -> frame_done pulses once. Reading (1,5) then returns 3'b101 (37%8) and (3,31) returns 3'b111.
- Swap boundary: keep frame_sync low after the load completes -> reads still return the old frame. Raise frame_sync once -> the read issued in the swap cycle returns old data, and the read one cycle later returns new data.
- Aborted load: raise cs_n after 100 bits, then pulse frame_sync -> no frame_done. Display is unchanged and load_ready stays 1.
- Load blocked: complete a frame, then attempt a second cs_n fall before frame_sync -> the second frame's bits are ignored. After the swap, the display shows the first frame.
- Read throughput: pix_req high for 32 consecutive cycles sweeping cols 0..31 of row 2 -> pix_valid is high for the 32 cycles delayed by 1, with the expected colours in order.

Source files
------------

// File: rtl/panel_frame_loader.sv
// Double-buffered RGB frame store: serial host loader on one side, 1-cycle
// latency pixel read port for the panel scan driver on the other.
module panel_frame_loader #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned CW   = $clog2(COLS),
    parameter int unsigned RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_sclk,
    input  logic          load_data,
    input  logic          load_cs_n,
    output logic          load_ready,
    input  logic          frame_sync,
    input  logic          pix_req,
    input  logic [RW-1:0] pix_row,
    input  logic [CW-1:0] pix_col,
    output logic          pix_valid,
    output logic [2:0]    pix_rgb,
    output logic          frame_done
);

    localparam int unsigned NPIX = ROWS * COLS;
    localparam int unsigned AW   = RW + CW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0] sclk_q;
    logic [1:0] data_q;
    logic [2:0] cs_q;
    logic       sclk_rise, cs_fall, cs_high, bit_in;

    logic [1:0]    bit_cnt;
    logic [1:0]    rg;
    logic [AW-1:0] pix_ptr;
    logic          disp_sel;
    logic          swap_pending;
    logic          swap;

    logic          start, shift_en, wr_en, complete;

    logic [NPIX-1:0][2:0] bank0;
    logic [NPIX-1:0][2:0] bank1;
    logic [AW-1:0]        rd_addr;

    // Host pins are asynchronous to clk; sclk/cs_n carry an extra flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= 3'b000;
            data_q <= 2'b00;
            cs_q   <= 3'b111;
        end else begin
            sclk_q <= {sclk_q[1:0], load_sclk};
            data_q <= {data_q[0], load_data};
            cs_q   <= {cs_q[1:0], load_cs_n};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign cs_high   = cs_q[1];
    assign bit_in    = data_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Loader next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        wr_en     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && load_ready) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_high) begin
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt == 2'd2) begin
                        wr_en = 1'b1;
                        if (pix_ptr == AW'(NPIX - 1)) begin
                            complete  = 1'b1;
                            state_nxt = FULL;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            FULL: begin
                if (cs_high && !swap_pending) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 2'd0;
            rg      <= 2'b00;
            pix_ptr <= '0;
        end else if (start) begin
            bit_cnt <= 2'd0;
            pix_ptr <= '0;
        end else if (wr_en) begin
            bit_cnt <= 2'd0;
            pix_ptr <= AW'(pix_ptr + 1'b1);
        end else if (shift_en) begin
            bit_cnt <= 2'(bit_cnt + 2'd1);
            rg      <= {rg[0], bit_in};
        end
    end

    // Completed pixel goes to whichever bank is not on display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (wr_en) begin
            if (disp_sel) bank0[pix_ptr] <= {rg, bit_in};
            else          bank1[pix_ptr] <= {rg, bit_in};
        end
    end

    assign swap       = frame_sync & swap_pending;
    assign frame_done = swap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_sel     <= 1'b0;
            swap_pending <= 1'b0;
            load_ready   <= 1'b1;
        end else if (complete) begin
            swap_pending <= 1'b1;
            load_ready   <= 1'b0;
        end else if (swap) begin
            disp_sel     <= ~disp_sel;
            swap_pending <= 1'b0;
            load_ready   <= 1'b1;
        end
    end

    assign rd_addr = {pix_row, pix_col};

    // Read uses the bank selection current at the request cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid <= 1'b0;
            pix_rgb   <= 3'b000;
        end else begin
            pix_valid <= pix_req;
            if (pix_req) pix_rgb <= disp_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: tb/tb_panel_frame_loader.sv
// Directed bench for panel_frame_loader: load, swap boundary, abort, blocked load,
// read throughput and asynchronous reset.
module tb_panel_frame_loader;

    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 4;
    localparam int unsigned CW   = 5;
    localparam int unsigned RW   = 2;
    localparam int unsigned NPIX = ROWS * COLS;

    logic          clk;
    logic          reset;
    logic          load_sclk;
    logic          load_data;
    logic          load_cs_n;
    logic          load_ready;
    logic          frame_sync;
    logic          pix_req;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic          pix_valid;
    logic [2:0]    pix_rgb;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    panel_frame_loader #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_sclk  (load_sclk),
        .load_data  (load_data),
        .load_cs_n  (load_cs_n),
        .load_ready (load_ready),
        .frame_sync (frame_sync),
        .pix_req    (pix_req),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [2:0] pat(input int kind, input int idx);
        logic [2:0] v;
        case (kind)
            0:       v = 3'(idx % 8);
            1:       v = 3'(7 - (idx % 8));
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    task automatic send_bit(input logic b);
        load_data = b;
        load_sclk = 1'b0;
        repeat (4) tick();
        load_sclk = 1'b1;
        repeat (4) tick();
        load_sclk = 1'b0;
    endtask

    task automatic load_frame(input int kind, input int nbits);
        logic [2:0] colour;
        load_cs_n = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < nbits; i++) begin
            colour = pat(kind, i / 3);
            send_bit(colour[2 - (i % 3)]);
        end
    endtask

    task automatic end_cs();
        load_cs_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pulse_sync(input string tag, input logic exp_done);
        frame_sync = 1'b1;
        #1 chk(tag, 8'(frame_done), 8'(exp_done));
        tick();
        frame_sync = 1'b0;
        #1 chk({tag, "_clr"}, 8'(frame_done), 8'h0);
        tick();
    endtask

    task automatic do_read(input string tag, input int r, input int c, input logic [2:0] exp);
        pix_req = 1'b1;
        pix_row = RW'(r);
        pix_col = CW'(c);
        tick();
        pix_req = 1'b0;
        chk({tag, "_valid"}, 8'(pix_valid), 8'h1);
        chk(tag, 8'(pix_rgb), 8'(exp));
    endtask

    initial begin
        reset      = 1'b0;
        load_sclk  = 1'b0;
        load_data  = 1'b0;
        load_cs_n  = 1'b1;
        frame_sync = 1'b0;
        pix_req    = 1'b0;
        pix_row    = '0;
        pix_col    = '0;
        repeat (3) tick();
        chk("rst_valid", 8'(pix_valid), 8'h0);
        chk("rst_rgb", 8'(pix_rgb), 8'h0);
        chk("rst_ready", 8'(load_ready), 8'h1);
        chk("rst_done", 8'(frame_done), 8'h0);
        reset = 1'b1;
        repeat (2) tick();
        do_read("rd_black_00", 0, 0, 3'b000);
        do_read("rd_black_331", 3, 31, 3'b000);

        // Frame A, held off the display until frame_sync
        load_frame(0, NPIX * 3);
        end_cs();
        chk("full_ready", 8'(load_ready), 8'h0);
        chk("full_nodone", 8'(frame_done), 8'h0);
        repeat (5) tick();
        do_read("pre_swap_15", 1, 5, 3'b000);

        // Swap boundary: read in swap cycle sees old bank, next cycle sees new
        frame_sync = 1'b1;
        pix_req    = 1'b1;
        pix_row    = 2'd1;
        pix_col    = 5'd5;
        #1 chk("swap_done", 8'(frame_done), 8'h1);
        chk("swap_ready_lo", 8'(load_ready), 8'h0);
        tick();
        frame_sync = 1'b0;
        chk("swap_rd_old_valid", 8'(pix_valid), 8'h1);
        chk("swap_rd_old", 8'(pix_rgb), 8'h0);
        #1 chk("swap_done_clr", 8'(frame_done), 8'h0);
        chk("swap_ready_hi", 8'(load_ready), 8'h1);
        tick();
        pix_req = 1'b0;
        chk("swap_rd_new", 8'(pix_rgb), 8'h5);
        do_read("a_331", 3, 31, 3'b111);
        do_read("a_23", 2, 3, 3'b011);

        // Full-rate sweep of row 2
        tick();
        chk("sweep_idle", 8'(pix_valid), 8'h0);
        pix_req = 1'b1;
        pix_row = 2'd2;
        pix_col = 5'd0;
        for (int c = 1; c < 32; c++) begin
            tick();
            chk("sweep_valid", 8'(pix_valid), 8'h1);
            chk("sweep_rgb", 8'(pix_rgb), 8'((64 + c - 1) % 8));
            pix_col = CW'(c);
        end
        tick();
        pix_req = 1'b0;
        chk("sweep_last_valid", 8'(pix_valid), 8'h1);
        chk("sweep_last", 8'(pix_rgb), 8'h7);
        tick();
        chk("sweep_end_valid", 8'(pix_valid), 8'h0);
        chk("sweep_hold", 8'(pix_rgb), 8'h7);

        // Aborted load after 100 bits
        load_frame(1, 100);
        end_cs();
        chk("abort_ready", 8'(load_ready), 8'h1);
        pulse_sync("abort_nodone", 1'b0);
        chk("abort_ready2", 8'(load_ready), 8'h1);
        do_read("abort_15", 1, 5, 3'b101);
        do_read("abort_00", 0, 0, 3'b000);

        // Frame B completes, then a blocked attempt before the swap
        load_frame(1, NPIX * 3);
        end_cs();
        chk("b_ready", 8'(load_ready), 8'h0);
        load_frame(2, 48);
        end_cs();
        chk("blk_ready", 8'(load_ready), 8'h0);
        do_read("blk_pre_00", 0, 0, 3'b000);
        pulse_sync("blk_swap", 1'b1);
        chk("blk_ready_hi", 8'(load_ready), 8'h1);
        do_read("b_00", 0, 0, 3'b111);
        do_read("b_01", 0, 1, 3'b110);
        do_read("b_15", 1, 5, 3'b010);
        do_read("b_331", 3, 31, 3'b000);

        // Asynchronous reset mid-load with a read in flight
        load_frame(0, 50);
        pix_req = 1'b1;
        pix_row = 2'd0;
        pix_col = 5'd0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("arst_valid", 8'(pix_valid), 8'h0);
        chk("arst_rgb", 8'(pix_rgb), 8'h0);
        chk("arst_ready", 8'(load_ready), 8'h1);
        pix_req   = 1'b0;
        load_cs_n = 1'b1;
        load_sclk = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        do_read("arst_rd_00", 0, 0, 3'b000);
        do_read("arst_rd_01", 0, 1, 3'b000);
        do_read("arst_rd_15", 1, 5, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end, observed %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
